// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit.
// Captures a load or store from the EXE->MEM pipeline register, runs a
// valid/ready request and a response wait against data memory, stalls the
// pipeline while busy and pulses LoadDoneW when a load result is ready.
// Optional build macro: LSU_ALIGN_CHECK_EN rejects word-misaligned accesses
// with a sticky error instead of silently dropping the low address bits.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no op in flight; capture a new op when ResultSrcM/WDMEM is high
// REQ   | mem_req_valid held with stable we/addr/wdata until mem_req_ready
// RSP   | load issued; waiting for mem_rsp_valid or the timeout
// DONE  | op finished; one-cycle LoadDoneW for loads, then back to IDLE
module mem_stage_lsu #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic             ResultSrcM,
  input  logic             WDMEM,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_rsp_valid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             StallM,
  output logic [WIDTH-1:0] ReadDataW,
  output logic [4:0]       RdW,
  output logic             RegWriteW,
  output logic             LoadDoneW,
  output logic             LsuErr
);

  // Wait counter must be able to hold TIMEOUT_CYCLES itself.
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic             op_load_q;
  logic [4:0]       rd_q;
  logic             rw_q;
  logic [CNT_W-1:0] wait_cnt_q;

  logic             req_valid_q;
  logic             we_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] read_data_q;
  logic [4:0]       rd_w_q;
  logic             reg_write_w_q;
  logic             load_done_q;
  logic             lsu_err_q;

  logic             op_valid;
  logic             misaligned;
  logic             unused_addr_lsbs;

  assign op_valid = ResultSrcM | WDMEM;

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = |ALUResultM[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // Low address bits only matter to the optional alignment check.
  assign unused_addr_lsbs = ^ALUResultM[1:0];

  // Sequencer: state, captured op, wait counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_load_q     <= 1'b0;
      rd_q          <= '0;
      rw_q          <= 1'b0;
      wait_cnt_q    <= '0;
      req_valid_q   <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      read_data_q   <= '0;
      rd_w_q        <= '0;
      reg_write_w_q <= 1'b0;
      load_done_q   <= 1'b0;
      lsu_err_q     <= 1'b0;
    end else begin
      // Writeback strobes are single-cycle unless re-armed below.
      load_done_q   <= 1'b0;
      reg_write_w_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (op_valid) begin
            op_load_q <= ResultSrcM;
            rd_q      <= RdM;
            rw_q      <= RegWriteM;
            if (misaligned) begin
              // Never reaches memory; a load still retires with zero data.
              lsu_err_q <= 1'b1;
              state_q   <= DONE;
              if (ResultSrcM) begin
                read_data_q   <= '0;
                rd_w_q        <= RdM;
                reg_write_w_q <= RegWriteM;
                load_done_q   <= 1'b1;
              end
            end else begin
              req_valid_q <= 1'b1;
              we_q        <= WDMEM;
              addr_q      <= {ALUResultM[WIDTH-1:2], 2'b00};
              wdata_q     <= WriteDataM;
              state_q     <= REQ;
            end
          end
        end

        REQ: begin
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            if (op_load_q) begin
              wait_cnt_q <= '0;
              state_q    <= RSP;
            end else begin
              state_q <= DONE;
            end
          end
        end

        RSP: begin
          // Data arriving on the timeout cycle takes priority over the error.
          if (mem_rsp_valid) begin
            read_data_q   <= mem_rdata;
            rd_w_q        <= rd_q;
            reg_write_w_q <= rw_q;
            load_done_q   <= 1'b1;
            state_q       <= DONE;
          end else if (wait_cnt_q == CNT_LIMIT) begin
            read_data_q   <= '0;
            rd_w_q        <= rd_q;
            reg_write_w_q <= rw_q;
            load_done_q   <= 1'b1;
            lsu_err_q     <= 1'b1;
            state_q       <= DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall is combinational so the pipeline freezes in the same cycle an op
  // appears; gated by reset so it reads 0 while reset is held.
  assign StallM = rst_n & ((state_q == IDLE && op_valid) ||
                           (state_q == REQ) || (state_q == RSP));

  assign mem_req_valid = req_valid_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign ReadDataW     = read_data_q;
  assign RdW           = rd_w_q;
  assign RegWriteW     = reg_write_w_q;
  assign LoadDoneW     = load_done_q;
  assign LsuErr        = lsu_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu (TIMEOUT_CYCLES = 4).
module tb_mem_stage_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ALUResultM, WriteDataM;
  logic [4:0]  RdM;
  logic        RegWriteM, ResultSrcM, WDMEM;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        StallM;
  logic [31:0] ReadDataW;
  logic [4:0]  RdW;
  logic        RegWriteW, LoadDoneW, LsuErr;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage_lsu #(.WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .WDMEM(WDMEM),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .StallM(StallM), .ReadDataW(ReadDataW), .RdW(RdW),
    .RegWriteW(RegWriteW), .LoadDoneW(LoadDoneW), .LsuErr(LsuErr)
  );

  always #5 clk = ~clk;

  // One memory operation plus the environment's behaviour around it.
  // dly: cycles ready stays low; rsp: RSP-cycle index carrying the data
  // (rsp > TO means no response at all).
  typedef struct {
    bit          ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    bit          rw;
    int          dly;
    int          rsp;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    bit          exp_err;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] model_mem[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"},  32'(StallM), 32'd0);
    chk({tag, "_valid"},  32'(mem_req_valid), 32'd0);
    chk({tag, "_we"},     32'(mem_we), 32'd0);
    chk({tag, "_addr"},   mem_addr, 32'd0);
    chk({tag, "_wdata"},  mem_wdata, 32'd0);
    chk({tag, "_rdata"},  ReadDataW, 32'd0);
    chk({tag, "_rdw"},    32'(RdW), 32'd0);
    chk({tag, "_regw"},   32'(RegWriteW), 32'd0);
    chk({tag, "_done"},   32'(LoadDoneW), 32'd0);
    chk({tag, "_err"},    32'(LsuErr), 32'd0);
  endtask

  // Garbage on the *M inputs while the unit is busy; it must be ignored.
  task automatic bubble(input bit allow_op);
    ALUResultM = $urandom;
    WriteDataM = $urandom;
    RdM        = 5'($urandom);
    RegWriteM  = 1'($urandom);
    if (allow_op) begin
      ResultSrcM = 1'($urandom);
      WDMEM      = ResultSrcM ? 1'b0 : 1'($urandom);
    end else begin
      ResultSrcM = 1'b0;
      WDMEM      = 1'b0;
    end
  endtask

  task automatic do_op(input vec_t v, input string tag);
    bit          timed_out = (v.rsp > TO);
    int          nrsp      = timed_out ? TO + 1 : v.rsp + 1;
    logic [31:0] exp_rdw   = timed_out ? 32'd0 : v.rdata;
    // capture cycle
    @(negedge clk);
    ResultSrcM = v.ld; WDMEM = !v.ld; ALUResultM = v.addr; WriteDataM = v.wdata;
    RdM = v.rd; RegWriteM = v.rw; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rdata = $urandom;
    #1;
    chk({tag, "_cap_stall"}, 32'(StallM), 32'd1);
    chk({tag, "_cap_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_cap_done"},  32'(LoadDoneW), 32'd0);
    // request cycles
    for (int i = 0; i <= v.dly; i++) begin
      @(negedge clk);
      bubble(1'b1);
      mem_req_ready = (i == v.dly);
      mem_rsp_valid = 1'($urandom);
      mem_rdata     = $urandom;
      #1;
      chk({tag, "_req_stall"}, 32'(StallM), 32'd1);
      chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd1);
      chk({tag, "_req_we"},    32'(mem_we), 32'(!v.ld));
      chk({tag, "_req_addr"},  mem_addr, v.exp_addr);
      if (!v.ld) chk({tag, "_req_wdata"}, mem_wdata, v.wdata);
    end
    // response wait
    if (v.ld) begin
      for (int j = 0; j < nrsp; j++) begin
        @(negedge clk);
        bubble(1'b1);
        mem_req_ready = 1'($urandom);
        mem_rsp_valid = (j == v.rsp);
        mem_rdata     = (j == v.rsp) ? v.rdata : $urandom;
        #1;
        chk({tag, "_rsp_stall"}, 32'(StallM), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(mem_req_valid), 32'd0);
      end
    end
    // completion cycle
    @(negedge clk);
    bubble(1'b0);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'($urandom);
    mem_rdata     = $urandom;
    #1;
    chk({tag, "_done_stall"}, 32'(StallM), 32'd0);
    chk({tag, "_done_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_done_pulse"}, 32'(LoadDoneW), 32'(v.ld));
    chk({tag, "_done_err"},   32'(LsuErr), 32'(v.exp_err));
    if (v.ld) begin
      chk({tag, "_done_rdata"}, ReadDataW, exp_rdw);
      chk({tag, "_done_rdw"},   32'(RdW), 32'(v.rd));
      chk({tag, "_done_regw"},  32'(RegWriteW), 32'(v.rw));
    end else begin
      chk({tag, "_done_regw"},  32'(RegWriteW), 32'd0);
    end
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;

    vecs[0] = '{1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0,  1'b0, 0, 0, 32'h0,         32'h0000_0100, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0020, 32'h0,         5'd5,  1'b1, 3, 1, 32'h1234_5678, 32'h0000_0020, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0044, 32'h0,         5'd9,  1'b1, 0, 0, 32'hCAFE_F00D, 32'h0000_0044, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0048, 32'h0BAD_C0DE, 5'd0,  1'b0, 0, 0, 32'h0,         32'h0000_0048, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0080, 32'h0,         5'd31, 1'b0, 1, TO, 32'hA5A5_5A5A, 32'h0000_0080, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_07FC, 32'h5555_AAAA, 5'd0,  1'b0, 2, 0, 32'h0,         32'h0000_07FC, 1'b0};
    vecs[6] = '{1'b1, 32'h1000_0004, 32'h0,         5'd1,  1'b1, 0, 2, 32'h0F0F_F0F0, 32'h1000_0004, 1'b0};

    for (int k = 0; k < 16; k++) model_mem[k] = $urandom;

    rst_n = 1'b0;
    ALUResultM = '0; WriteDataM = '0; RdM = '0; RegWriteM = 1'b0;
    ResultSrcM = 1'b0; WDMEM = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // directed table, consecutive ops back to back
    for (int t = 0; t < 7; t++) do_op(vecs[t], $sformatf("vec%0d", t));

    // randomized ops against a word-array memory model
    for (int r = 0; r < 40; r++) begin
      int idx = $urandom_range(0, 15);
      v.ld       = 1'($urandom);
      v.addr     = 32'h200 + 32'(idx * 4);
      v.exp_addr = v.addr;
      v.wdata    = $urandom;
      v.rd       = 5'($urandom);
      v.rw       = 1'($urandom);
      v.dly      = $urandom_range(0, 3);
      v.rsp      = $urandom_range(0, TO);
      v.rdata    = model_mem[idx];
      v.exp_err  = 1'b0;
      do_op(v, $sformatf("rnd%0d", r));
      if (!v.ld) model_mem[idx] = v.wdata;
    end

    // no response at all: timeout error with zero data
    v = '{1'b1, 32'h0000_0300, 32'h0, 5'd12, 1'b1, 0, TO + 1, 32'hFFFF_FFFF, 32'h0000_0300, 1'b1};
    do_op(v, "timeout");

    // async reset while waiting in RSP
    @(negedge clk);
    ResultSrcM = 1'b1; WDMEM = 1'b0; ALUResultM = 32'h40; RdM = 5'd3; RegWriteM = 1'b1;
    @(negedge clk);
    bubble(1'b0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    chk("rstrsp_pre_stall", 32'(StallM), 32'd1);
    chk("rstrsp_pre_err",   32'(LsuErr), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rstrsp");
    @(negedge clk);
    rst_n = 1'b1;
    v = '{1'b1, 32'h0000_0040, 32'h0, 5'd3, 1'b1, 0, 0, 32'h7777_1111, 32'h0000_0040, 1'b0};
    do_op(v, "postrst");

    // misaligned access
`ifdef LSU_ALIGN_CHECK_EN
    @(negedge clk);
    ResultSrcM = 1'b1; WDMEM = 1'b0; ALUResultM = 32'h103; RdM = 5'd7; RegWriteM = 1'b1;
    #1;
    chk("mis_cap_stall", 32'(StallM), 32'd1);
    chk("mis_cap_valid", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    bubble(1'b0);
    #1;
    chk("mis_done_stall", 32'(StallM), 32'd0);
    chk("mis_done_valid", 32'(mem_req_valid), 32'd0);
    chk("mis_done_err",   32'(LsuErr), 32'd1);
    chk("mis_done_pulse", 32'(LoadDoneW), 32'd1);
    chk("mis_done_rdata", ReadDataW, 32'd0);
    chk("mis_done_rdw",   32'(RdW), 32'd7);
    @(negedge clk);
    #1;
    chk("mis_after_valid", 32'(mem_req_valid), 32'd0);
    chk("mis_after_pulse", 32'(LoadDoneW), 32'd0);
`else
    v = '{1'b0, 32'h0000_0103, 32'h1357_9BDF, 5'd0, 1'b0, 1, 0, 32'h0, 32'h0000_0100, 1'b0};
    do_op(v, "misalign");
    chk("misalign_addr_hold", mem_addr, 32'h0000_0100);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit on the consuming side of the EXE→MEM pipeline register. It takes the MEM-stage control and data signals, runs a valid/ready request plus response transaction against the data memory, and drives `StallM` back to the pipeline registers while a memory operation is outstanding. Completed loads are presented to writeback with a one-cycle valid pulse.

## Interface
Parameters:
- `WIDTH`, 32: data and address width.
- `TIMEOUT_CYCLES`, 255: maximum number of cycles spent waiting for a load response before the unit aborts.

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `ALUResultM`, in, WIDTH: byte address of the memory operation.
- `WriteDataM`, in, WIDTH: store data.
- `RdM`, in, 5: destination register of a load.
- `RegWriteM`, in, 1: register write enable. Passed through on loads.
- `ResultSrcM`, in, 1: 1 marks a load.
- `WDMEM`, in, 1: 1 marks a store. Never high together with `ResultSrcM`.
- `mem_req_valid`, out, 1: request valid.
- `mem_req_ready`, in, 1: memory accepts the request.
- `mem_we`, out, 1: 1 for a store, 0 for a load.
- `mem_addr`, out, WIDTH: word-aligned address, `{addr[WIDTH-1:2],2'b00}`.
- `mem_wdata`, out, WIDTH: store data.
- `mem_rsp_valid`, in, 1: load data valid.
- `mem_rdata`, in, WIDTH: load data.
- `StallM`, out, 1: stall request to the pipeline registers.
- `ReadDataW`, out, WIDTH: loaded word.
- `RdW`, out, 5: destination register of the completed load.
- `RegWriteW`, out, 1: write enable for the completed load.
- `LoadDoneW`, out, 1: one-cycle pulse when `ReadDataW`, `RdW` and `RegWriteW` are valid.
- `LsuErr`, out, 1: sticky error flag. Cleared only by reset.

## Operation
State machine states: IDLE, REQ, RSP, DONE.

- **IDLE**
  - When `ResultSrcM` or `WDMEM` is high, capture the following into internal registers: address, write data, `RdM`, `RegWriteM`, and the op type. Then go to REQ.
  - Otherwise stay in IDLE.
  - The `*M` inputs are ignored in every state except IDLE. The pipeline register loads bubbles while stalled; the captured copy is authoritative.
- **REQ**
  - Hold `mem_req_valid`=1, with `mem_we`, `mem_addr` and `mem_wdata` stable, until `mem_req_ready`=1.
  - On the handshake, a store goes to DONE and a load goes to RSP.
- **RSP**
  - Wait for `mem_rsp_valid`. On it, register `mem_rdata` into `ReadDataW` and go to DONE.
  - A wait counter starts at 0 on entry to RSP and increments each cycle.
  - When the counter reaches `TIMEOUT_CYCLES`, set `LsuErr`=1, force `ReadDataW`=0, and go to DONE.
  - If `mem_rsp_valid` arrives in the same cycle as the timeout, the data wins and no error is raised.
- **DONE**
  - For loads: `LoadDoneW`=1 for this cycle only, with `RdW` and `RegWriteW` taken from the captured copy.
  - Return to IDLE.
  - A new op present in IDLE on the next cycle is accepted normally, so back-to-back operations are supported.
- **`StallM`** is combinational:
  - 1 when in IDLE and an op is present;
  - 1 when in REQ or RSP;
  - 0 when in DONE, and 0 when in IDLE with no op.
- A store produces no writeback: `LoadDoneW`=0 and `RegWriteW`=0.
- `mem_rsp_valid` is ignored in states other than RSP.
- Reset asserted mid-transaction:
  - All state returns immediately to IDLE and every output returns to its reset value.
  - An in-flight memory request is abandoned. Memory-side cleanup is the memory's responsibility.

## Timing
- Reset values: `mem_req_valid`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `StallM`=0, `ReadDataW`=0, `RdW`=0, `RegWriteW`=0, `LoadDoneW`=0, `LsuErr`=0.
- **Store latency**, with ready asserted immediately: the op is seen in cycle 0 (stall=1). `mem_req_valid` is high in cycle 1, when the handshake occurs. DONE is cycle 2, with stall=0.
- **Load latency**, with ready immediate and response one cycle after the handshake:
  - cycle 0: capture;
  - cycle 1: handshake;
  - cycle 2: `mem_rsp_valid`;
  - cycle 3: `LoadDoneW` is high.
  - Total: 3 stall cycles.
- **Request outputs** are registered and must not change while `mem_req_valid`=1 and `mem_req_ready`=0.
- **Low address bits:** `ALUResultM[1:0]` is dropped. Only word accesses are supported.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - In IDLE, an op whose `ALUResultM[1:0]`≠0 is not issued to memory.
  - The unit sets `LsuErr`=1 and goes directly to DONE. A load returns `ReadDataW`=0 with `LoadDoneW`=1.
  - `StallM` is high for one cycle.
- `LSU_ALIGN_CHECK_EN` undefined: the low bits are silently dropped and the op is issued to the aligned word.

## Test plan
- **Store, immediate ready:** `WDMEM`=1, addr 0x100, data 0xDEADBEEF. Requires `mem_we`=1, `mem_addr`=0x100, `mem_wdata`=0xDEADBEEF, `StallM` high for 2 cycles, and no `LoadDoneW`.
- **Load with backpressure and latency:** `ResultSrcM`=1, addr 0x20, `RdM`=5, ready delayed 3 cycles, rsp=0x12345678 two cycles after the handshake. Requires the request held stable, then `LoadDoneW` pulse with `ReadDataW`=0x12345678, `RdW`=5, `RegWriteW`=1.
- **Back-to-back:** a load then a store on consecutive IDLE cycles. Requires both transactions issued in order, and `StallM` low only during each DONE cycle.
- **Timeout:** `TIMEOUT_CYCLES`=4, no response. Requires `LsuErr`=1, `ReadDataW`=0, `LoadDoneW` pulse, then return to IDLE. Also, a response in the timeout cycle gives the data with `LsuErr`=0.
- **Reset mid-RSP:** drop `rst_n` while in RSP. All outputs go to 0 asynchronously, and the next load after reset completes normally.
- **Misaligned access:** addr 0x103 with `LSU_ALIGN_CHECK_EN` defined gives `LsuErr`=1 and no `mem_req_valid`. With the macro undefined, it gives `mem_addr`=0x100.
